// File: rtl/imem_pkg.sv
// Shared types and sizes for the instruction-memory line fetcher.
package imem_pkg;

    localparam int unsigned DATA_W = 48;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORDS  = 5;
    localparam int unsigned CNT_W  = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Word k of a line sits at [k*DATA_W +: DATA_W]; k=0 feeds Engine lane _1
    typedef logic [WORDS-1:0][DATA_W-1:0] line_t;

    typedef struct packed {
        logic [ADDR_W-1:0] base1;
        logic [ADDR_W-1:0] base2;
    } base_pair_t;

    // Issue address for word k; wraps modulo 2^ADDR_W
    function automatic logic [ADDR_W-1:0] issue_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [CNT_W-1:0]  k);
        return base + ADDR_W'(k);
    endfunction

endpackage

// File: rtl/imem_line_fetcher_if.sv
// Controller / SRAM / Engine signal bundle of the line fetcher.
interface imem_line_fetcher_if;
    import imem_pkg::*;

    logic              start;
    logic [ADDR_W-1:0] base_addr1;
    logic [ADDR_W-1:0] base_addr2;
    logic [ADDR_W-1:0] address1;
    logic [ADDR_W-1:0] address2;
    logic              sram_rd_en;
    logic [DATA_W-1:0] sram_data1;
    logic [DATA_W-1:0] sram_data2;
    line_t             line1;
    line_t             line2;
    logic              line_valid;
    logic              line_ready;
    logic              busy;

    modport master (
        output start, base_addr1, base_addr2, sram_data1, sram_data2, line_ready,
        input  address1, address2, sram_rd_en, line1, line2, line_valid, busy
    );

    modport slave (
        input  start, base_addr1, base_addr2, sram_data1, sram_data2, line_ready,
        output address1, address2, sram_rd_en, line1, line2, line_valid, busy
    );

endinterface

// File: rtl/rd_valid_pipe.sv
// Delays the SRAM read strobe by RD_LAT cycles to mark returning read data.
module rd_valid_pipe #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic rd_en,
    output logic cap_en
);

    logic [RD_LAT-1:0] stage_q;

    // Async clear discards any reads still in flight
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= rd_en;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign cap_en = stage_q[RD_LAT-1];

endmodule

// File: rtl/imem_line_fetcher.sv
// Walks two SRAM banks from latched bases, assembles one line per bank and
// hands both lines to the Engine with a valid/ready handshake.
module imem_line_fetcher
    import imem_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    imem_line_fetcher_if.slave bus,
    output logic [DATA_W-1:0] iMem_data1_1,
    output logic [DATA_W-1:0] iMem_data1_2,
    output logic [DATA_W-1:0] iMem_data1_3,
    output logic [DATA_W-1:0] iMem_data1_4,
    output logic [DATA_W-1:0] iMem_data1_5,
    output logic [DATA_W-1:0] iMem_data2_1,
    output logic [DATA_W-1:0] iMem_data2_2,
    output logic [DATA_W-1:0] iMem_data2_3,
    output logic [DATA_W-1:0] iMem_data2_4,
    output logic [DATA_W-1:0] iMem_data2_5
);

    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);

    state_e            state_q, state_d;
    base_pair_t        base_q, base_d;
    logic [CNT_W-1:0]  iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]  cap_cnt_q;
    logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
    logic              rd_en_q, rd_en_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              launch_c;
    logic              cap_en;
    line_t             line1_q, line2_q;

    rd_valid_pipe #(.RD_LAT(RD_LAT)) u_rd_valid_pipe (
        .clock  (clock),
        .reset  (reset),
        .rd_en  (rd_en_q),
        .cap_en (cap_en)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        iss_cnt_d = iss_cnt_q;
        addr1_d   = addr1_q;
        addr2_d   = addr2_q;
        rd_en_d   = 1'b0;
        valid_d   = valid_q;
        launch_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) launch_c = 1'b1;
            end
            FETCH: begin
                if (iss_cnt_q == WORDS_C) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    addr1_d   = issue_addr(base_q.base1, iss_cnt_q);
                    addr2_d   = issue_addr(base_q.base2, iss_cnt_q);
                    iss_cnt_d = iss_cnt_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cap_en && cap_cnt_q == LAST_C) begin
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (bus.line_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    if (bus.start) launch_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepted start issues word 0 straight away from the live bases
        if (launch_c) begin
            state_d   = FETCH;
            base_d    = '{base1: bus.base_addr1, base2: bus.base_addr2};
            rd_en_d   = 1'b1;
            addr1_d   = bus.base_addr1;
            addr2_d   = bus.base_addr2;
            iss_cnt_d = CNT_W'(1);
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            iss_cnt_q <= '0;
            addr1_q   <= '0;
            addr2_q   <= '0;
            rd_en_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            iss_cnt_q <= iss_cnt_d;
            addr1_q   <= addr1_d;
            addr2_q   <= addr2_d;
            rd_en_q   <= rd_en_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    // Line capture: each marked cycle fills the next word slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cap_cnt_q <= '0;
            line1_q   <= '0;
            line2_q   <= '0;
        end else if (launch_c) begin
            cap_cnt_q <= '0;
        end else if (cap_en && cap_cnt_q < WORDS_C) begin
            line1_q[cap_cnt_q] <= bus.sram_data1;
            line2_q[cap_cnt_q] <= bus.sram_data2;
            cap_cnt_q          <= cap_cnt_q + CNT_W'(1);
        end
    end

    assign bus.address1   = addr1_q;
    assign bus.address2   = addr2_q;
    assign bus.sram_rd_en = rd_en_q;
    assign bus.line1      = line1_q;
    assign bus.line2      = line2_q;
    assign bus.line_valid = valid_q;
    assign bus.busy       = busy_q;

    assign iMem_data1_1 = line1_q[0];
    assign iMem_data1_2 = line1_q[1];
    assign iMem_data1_3 = line1_q[2];
    assign iMem_data1_4 = line1_q[3];
    assign iMem_data1_5 = line1_q[4];
    assign iMem_data2_1 = line2_q[0];
    assign iMem_data2_2 = line2_q[1];
    assign iMem_data2_3 = line2_q[2];
    assign iMem_data2_4 = line2_q[3];
    assign iMem_data2_5 = line2_q[4];

endmodule

// File: tb/tb_imem_line_fetcher.sv
// Scoreboard bench for imem_line_fetcher with a behavioural SRAM and line model.
module tb_imem_line_fetcher;
    import imem_pkg::*;

    localparam int unsigned RD_LAT = 1;

    typedef struct {
        line_t       l1;
        line_t       l2;
        int unsigned t_done;
    } exp_line_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int unsigned cyc = 0;
    int checks = 0;
    int errors = 0;

    imem_line_fetcher_if bus();
    logic [DATA_W-1:0] lane1 [WORDS];
    logic [DATA_W-1:0] lane2 [WORDS];

    imem_line_fetcher #(.RD_LAT(RD_LAT)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .iMem_data1_1 (lane1[0]),
        .iMem_data1_2 (lane1[1]),
        .iMem_data1_3 (lane1[2]),
        .iMem_data1_4 (lane1[3]),
        .iMem_data1_5 (lane1[4]),
        .iMem_data2_1 (lane2[0]),
        .iMem_data2_2 (lane2[1]),
        .iMem_data2_3 (lane2[2]),
        .iMem_data2_4 (lane2[3]),
        .iMem_data2_5 (lane2[4])
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural SRAM banks: contents plus an RD_LAT-deep read return pipe
    logic [DATA_W-1:0] mem1 [256];
    logic [DATA_W-1:0] mem2 [256];
    logic [DATA_W-1:0] p1 [RD_LAT];
    logic [DATA_W-1:0] p2 [RD_LAT];

    always @(posedge clock) begin
        p1[0] <= bus.sram_rd_en ? mem1[bus.address1] : DATA_W'({$urandom, $urandom});
        p2[0] <= bus.sram_rd_en ? mem2[bus.address2] : DATA_W'({$urandom, $urandom});
        for (int i = 1; i < int'(RD_LAT); i++) begin
            p1[i] <= p1[i-1];
            p2[i] <= p2[i-1];
        end
    end
    assign bus.sram_data1 = p1[RD_LAT-1];
    assign bus.sram_data2 = p2[RD_LAT-1];

    exp_line_t                line_q[$];
    logic [2*ADDR_W-1:0]      addr_q[$];
    exp_line_t                cur;
    logic                     prev_valid = 1'b0;
    logic                     prev_ready = 1'b0;

    task automatic chk(input string name, input logic [WORDS*DATA_W-1:0] act,
                       input logic [WORDS*DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks every read issue and every line presentation against the queues
    always @(negedge clock) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (bus.sram_rd_en) begin
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h/%0h expected no read",
                             bus.address1, bus.address2);
                end else begin
                    chk("issue_addr", {bus.address1, bus.address2}, addr_q.pop_front());
                end
            end
            if (bus.line_valid && !prev_valid) begin
                if (line_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_line: got line_valid=1 expected 0");
                end else begin
                    cur = line_q.pop_front();
                    chk("valid_cycle", cyc, cur.t_done);
                    chk("line1", bus.line1, cur.l1);
                    chk("line2", bus.line2, cur.l2);
                    for (int k = 0; k < int'(WORDS); k++) begin
                        chk("lane1", lane1[k], cur.l1[k]);
                        chk("lane2", lane2[k], cur.l2[k]);
                    end
                end
            end else if (prev_valid && !prev_ready) begin
                chk("valid_held", bus.line_valid, 1);
                chk("line1_stable", bus.line1, cur.l1);
                chk("line2_stable", bus.line2, cur.l2);
            end else if (prev_valid && prev_ready) begin
                chk("valid_drop", bus.line_valid, 0);
                chk("line1_persist", bus.line1, cur.l1);
            end
            prev_valid = bus.line_valid;
            prev_ready = bus.line_ready;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present start with bases; record what the model expects from this fetch
    task automatic launch(input logic [ADDR_W-1:0] b1, input logic [ADDR_W-1:0] b2);
        exp_line_t e;
        logic [ADDR_W-1:0] a1, a2;
        for (int k = 0; k < int'(WORDS); k++) begin
            a1 = ADDR_W'((int'(b1) + k) % 256);
            a2 = ADDR_W'((int'(b2) + k) % 256);
            e.l1[k] = mem1[a1];
            e.l2[k] = mem2[a2];
            addr_q.push_back({a1, a2});
        end
        e.t_done = cyc + 1 + WORDS + RD_LAT;
        line_q.push_back(e);
        bus.start      = 1'b1;
        bus.base_addr1 = b1;
        bus.base_addr2 = b2;
    endtask

    // Wait (bounded) for line_valid with ready low, sprinkling ignored start pulses
    task automatic wait_valid();
        int n = 0;
        bus.line_ready = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.line_valid) break;
            n++;
            if (n > 64) begin
                checks++; errors++;
                $display("FAIL valid_timeout: got line_valid=0 expected 1 within 64 cycles");
                break;
            end
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.base_addr1 = ADDR_W'($urandom);
            bus.base_addr2 = ADDR_W'($urandom);
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            bus.start      = $urandom_range(0, 1) == 1;
            bus.base_addr1 = ADDR_W'($urandom);
            bus.base_addr2 = ADDR_W'($urandom);
            tick();
        end
        bus.start = 1'b0;
    endtask

    task automatic handshake(input bit b2b, input logic [ADDR_W-1:0] b1,
                             input logic [ADDR_W-1:0] b2);
        bus.line_ready = 1'b1;
        if (b2b) launch(b1, b2);
        else bus.start = 1'b0;
        tick();
        bus.line_ready = 1'b0;
        bus.start      = 1'b0;
        if (b2b) begin
            chk("b2b_rd_en", bus.sram_rd_en, 1);
            chk("b2b_busy", bus.busy, 1);
            chk("b2b_addr1", bus.address1, b1);
        end else begin
            chk("done_valid", bus.line_valid, 0);
            chk("done_busy", bus.busy, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_addr"}, {bus.address1, bus.address2}, 0);
        chk({tag, "_rd_en"}, bus.sram_rd_en, 0);
        chk({tag, "_valid"}, bus.line_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_line1"}, bus.line1, 0);
        chk({tag, "_line2"}, bus.line2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        bit pend;
        bus.start      = 1'b0;
        bus.base_addr1 = '0;
        bus.base_addr2 = '0;
        bus.line_ready = 1'b0;
        for (int a = 0; a < 256; a++) begin
            mem1[a] = DATA_W'(a);
            mem2[a] = DATA_W'(a);
        end
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic fetch, then long back-pressure with ignored starts
        launch(8'h10, 8'h80);
        tick();
        bus.start = 1'b0;
        wait_valid();
        hold(20);
        handshake(1'b0, 8'h00, 8'h00);

        // Address wrap, then back-to-back start in the handshake cycle
        launch(8'hFD, 8'hFE);
        tick();
        bus.start = 1'b0;
        wait_valid();
        hold(2);
        handshake(1'b1, 8'h40, 8'hC0);
        wait_valid();
        handshake(1'b0, 8'h00, 8'h00);

        // Reset in the third cycle of a fetch, then a clean refetch
        launch(8'h90, 8'h30);
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        line_q.delete();
        addr_q.delete();
        tick();
        tick();
        reset = 1'b0;
        tick();
        launch(8'h20, 8'h20);
        tick();
        bus.start = 1'b0;
        wait_valid();
        handshake(1'b0, 8'h00, 8'h00);

        // Randomized traffic over random memory contents
        for (int a = 0; a < 256; a++) begin
            mem1[a] = DATA_W'({$urandom, $urandom});
            mem2[a] = DATA_W'({$urandom, $urandom});
        end
        pend = 1'b0;
        for (int it = 0; it < 25; it++) begin
            if (!pend) begin
                launch(ADDR_W'($urandom), ADDR_W'($urandom));
                tick();
            end
            for (int j = 0; j < 3; j++) begin
                bus.line_ready = $urandom_range(0, 1) == 1;
                bus.start      = $urandom_range(0, 1) == 1;
                bus.base_addr1 = ADDR_W'($urandom);
                bus.base_addr2 = ADDR_W'($urandom);
                tick();
            end
            bus.line_ready = 1'b0;
            bus.start      = 1'b0;
            wait_valid();
            hold($urandom_range(0, 4));
            pend = (it < 24) && ($urandom_range(0, 1) == 1);
            handshake(pend, ADDR_W'($urandom), ADDR_W'($urandom));
        end

        repeat (4) tick();
        chk("queues_empty", line_q.size() + addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
